// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_pkg
//  Description : Shared Keccak-f[1600] definitions for the lane-serial theta
//                datapath: lane geometry, lane index helpers, lane rotation
//                and the theta stream state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    // Lane width in bits; only 64-bit lanes (Keccak-f[1600]) are supported.
    localparam int LANE_W    = 64;
    // Number of lanes in the 5x5 state.
    localparam int NUM_LANES = 25;

    // Lane-serial theta sequencing: collect, compute D, emit.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Column (x) coordinate of linear lane index i = x + 5*y.
    function automatic logic [2:0] x_of(input logic [4:0] i);
        return 3'(i % 5'd5);
    endfunction

    // Row (y) coordinate of linear lane index i = x + 5*y.
    function automatic logic [2:0] y_of(input logic [4:0] i);
        return 3'(i / 5'd5);
    endfunction

    // Rotate a lane left by n bit positions (bit z moves to bit z+n),
    // with the amount taken modulo the lane width.
    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v,
                                               input int unsigned      n);
        int unsigned amt;
        amt = n % LANE_W;
        if (amt == 0) begin
            return v;
        end
        return (v << amt) | (v >> (LANE_W - amt));
    endfunction

endpackage : keccak_pkg
`default_nettype wire

// File: rtl/keccak_theta_d.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_theta_d
//  Description : Combinational theta D network. From the five column
//                parities C[0..4] it forms
//                    D[x] = C[(x+4)%5] ^ rotl(C[(x+1)%5], 1)
//                for all five columns. Pure XOR/wiring, no state, so it can
//                be reused as-is inside an unrolled round.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_theta_d
    import keccak_pkg::*;
(
    input  logic [5*LANE_W-1:0] i_c_flat,   // C[x] at bits [x*LANE_W +: LANE_W]
    output logic [5*LANE_W-1:0] o_d_flat    // D[x] at bits [x*LANE_W +: LANE_W]
);

    // One D lane per column: left neighbour parity XOR rotated right neighbour.
    generate
        for (genvar x = 0; x < 5; x++) begin : g_col
            localparam int c_x_left  = (x + 4) % 5;
            localparam int c_x_right = (x + 1) % 5;

            assign o_d_flat[x*LANE_W +: LANE_W] =
                i_c_flat[c_x_left*LANE_W +: LANE_W] ^
                rotl(i_c_flat[c_x_right*LANE_W +: LANE_W], 1);
        end
    endgenerate

endmodule : keccak_theta_d
`default_nettype wire

// File: rtl/keccak_theta_stream.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_theta_stream
//  Description : Lane-serial Keccak-f[1600] theta step. Accepts 25 lanes in
//                index order (i = x + 5*y), buffers them while folding each
//                lane into its column parity C[x], registers D in a single
//                CALC cycle, then emits buf[i] ^ D[x] for i = 0..24 with a
//                valid/ready handshake. Load and drain never overlap.
//  Options     : KECCAK_THETA_BYPASS_EN - adds input theta_bypass; when high
//                during CALC, D is registered as zero so lanes pass through
//                unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_theta_stream
    import keccak_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
`ifdef KECCAK_THETA_BYPASS_EN
    input  logic              theta_bypass,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_lane,
    output logic [4:0]        out_idx,
    output logic              out_last,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;
    logic [4:0]         r_cnt;                  // lane index for load and drain
    logic [LANE_W-1:0]  r_c   [0:4];            // running column parities
    logic [LANE_W-1:0]  r_d   [0:4];            // registered theta D lanes
    logic [LANE_W-1:0]  r_buf [0:NUM_LANES-1];  // buffered input state

    logic [5*LANE_W-1:0] w_c_flat;
    logic [5*LANE_W-1:0] w_d_flat;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_cnt_last;
    logic               w_d_zero;
    logic [2:0]         w_col;
    logic [4:0]         w_cnt_inc;

    // ------------------------------------------------------------------------
    // Handshake and counter decode (registers only feed the outputs)
    // ------------------------------------------------------------------------
    assign in_ready   = (r_state == LOAD);
    assign out_valid  = (r_state == DRAIN);
    assign w_in_fire  = in_valid  & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_cnt_last = (r_cnt == 5'(NUM_LANES - 1));
    assign w_cnt_inc  = w_cnt_last ? 5'd0 : (r_cnt + 5'd1);
    assign w_col      = x_of(r_cnt);

`ifdef KECCAK_THETA_BYPASS_EN
    assign w_d_zero = theta_bypass;
`else
    assign w_d_zero = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Theta D network over the current column parities
    // ------------------------------------------------------------------------
    generate
        for (genvar x = 0; x < 5; x++) begin : g_c_flat
            assign w_c_flat[x*LANE_W +: LANE_W] = r_c[x];
        end
    endgenerate

    keccak_theta_d u_theta_d (
        .i_c_flat (w_c_flat),
        .o_d_flat (w_d_flat)
    );

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register; reset discards any partially loaded or drained state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: 25 accepted lanes -> CALC -> DRAIN -> 25 handshakes -> LOAD.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOAD: begin
                if (w_in_fire && w_cnt_last) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                w_next_state = DRAIN;
            end
            DRAIN: begin
                if (w_out_fire && w_cnt_last) begin
                    w_next_state = LOAD;
                end
            end
            default: begin
                w_next_state = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Lane counter, column parity accumulation and D capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 5'd0;
            for (int x = 0; x < 5; x++) begin
                r_c[x] <= '0;
                r_d[x] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_in_fire) begin
                        r_c[w_col] <= r_c[w_col] ^ in_lane;
                        r_cnt      <= w_cnt_inc;
                    end
                end
                CALC: begin
                    for (int x = 0; x < 5; x++) begin
                        r_d[x] <= w_d_zero ? '0 : w_d_flat[x*LANE_W +: LANE_W];
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        r_cnt <= w_cnt_inc;
                        // Parities must start from zero for the next state.
                        if (w_cnt_last) begin
                            for (int x = 0; x < 5; x++) begin
                                r_c[x] <= '0;
                            end
                        end
                    end
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    // Lane buffer: plain storage without reset, every slot is rewritten
    // before it is read in the following drain.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_buf[r_cnt] <= in_lane;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from registers; zero outside DRAIN)
    // ------------------------------------------------------------------------

    // Theta-transformed lane and its index for the current drain slot.
    always_comb begin
        out_lane = '0;
        out_idx  = 5'd0;
        out_last = 1'b0;
        if (out_valid) begin
            out_lane = r_buf[r_cnt] ^ r_d[w_col];
            out_idx  = r_cnt;
            out_last = w_cnt_last;
        end
    end

    // Busy whenever any lane of a state is held or in flight.
    assign busy = !((r_state == LOAD) && (r_cnt == 5'd0));

endmodule : keccak_theta_stream
`default_nettype wire

// File: tb/tb_keccak_theta_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keccak_theta_stream
//  Description : Self-checking bench for keccak_theta_stream. Stimulus states
//                are directed or $urandom; expected lanes come from a
//                column-parity model of theta and are queued, then compared
//                against every output beat by a single negedge monitor.
//  Options     : KECCAK_THETA_BYPASS_EN - also drives theta_bypass and runs
//                the pass-through case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_theta_stream;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_lane;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_lane;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
`ifdef KECCAK_THETA_BYPASS_EN
    logic        theta_bypass;
`endif

    keccak_theta_stream dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef KECCAK_THETA_BYPASS_EN
        .theta_bypass (theta_bypass),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane      (in_lane),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane     (out_lane),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: theta from its definition on a whole 25-lane state
    // ------------------------------------------------------------------------
    typedef struct {
        logic [4:0]  idx;
        logic [63:0] lane;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] stim     [25];
    logic [63:0] exp_lane [25];

    function automatic logic [63:0] rot1(input logic [63:0] v);
        return (v << 1) | (v >> 63);
    endfunction

    task automatic compute_model(input bit byp);
        logic [63:0] c [5];
        logic [63:0] d [5];
        for (int x = 0; x < 5; x++) c[x] = 64'd0;
        for (int i = 0; i < 25; i++) c[i % 5] = c[i % 5] ^ stim[i];
        for (int x = 0; x < 5; x++)
            d[x] = byp ? 64'd0 : (c[(x + 4) % 5] ^ rot1(c[(x + 1) % 5]));
        for (int i = 0; i < 25; i++) exp_lane[i] = stim[i] ^ d[i % 5];
    endtask

    // ------------------------------------------------------------------------
    // Output ready generator
    // ------------------------------------------------------------------------
    bit rdy_rand = 1'b0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: every valid output beat against the model queue
    // ------------------------------------------------------------------------
    bit          prev_stall = 1'b0;
    logic [63:0] prev_lane;
    logic [4:0]  prev_idx;
    logic        prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_lane",  out_lane, prev_lane);
                check("hold_idx",   64'(out_idx), 64'(prev_idx));
                check("hold_last",  64'(out_last), 64'(prev_last));
            end
            if (out_valid) begin
                check("in_ready_low_in_drain", 64'(in_ready), 64'd0);
                check("busy_in_drain", 64'(busy), 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("out_lane", out_lane, exp_q[0].lane);
                    check("out_idx",  64'(out_idx), 64'(exp_q[0].idx));
                    check("out_last", 64'(out_last), 64'(exp_q[0].idx == 5'd24));
                    if (out_ready) exp_q.pop_front();
                end
                prev_lane  = out_lane;
                prev_idx   = out_idx;
                prev_last  = out_last;
                prev_stall = !out_ready;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus tasks
    // ------------------------------------------------------------------------

    // Feed stim[0..24]; gap_pct = chance of an idle cycle before each lane.
    // hold_in leaves in_valid high with junk during the drain.
    task automatic send_state(input int gap_pct, input bit byp, input bit hold_in);
        int guard;
        compute_model(byp);
        for (int i = 0; i < 25; i++) exp_q.push_back('{idx: 5'(i), lane: exp_lane[i]});
        for (int i = 0; i < 25; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_lane  = {$urandom, $urandom};
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_lane  = stim[i];
            guard    = 0;
            @(negedge clk);
            while (!in_ready && guard < 1000) begin
                guard++;
                @(negedge clk);
            end
            if (guard >= 1000) check("in_ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            if (i == 0) check("busy_mid_load", 64'(busy), 64'd1);
        end
        in_valid = hold_in;
        in_lane  = {$urandom, $urandom};
        // Last lane accepted at the edge just passed: CALC now, DRAIN next.
        @(negedge clk);
        check("latency_calc_no_valid", 64'(out_valid), 64'd0);
        check("latency_calc_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("latency_first_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_complete", 64'(guard < 3000), 64'd1);
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_drain", 64'(in_ready), 64'd1);
        check("idle_after_drain", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_single(input int idx, input logic [63:0] v);
        for (int i = 0; i < 25; i++) stim[i] = 64'd0;
        stim[idx] = v;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int guard;
        in_valid = 1'b0;
        in_lane  = 64'd0;
`ifdef KECCAK_THETA_BYPASS_EN
        theta_bypass = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_lane",  out_lane, 64'd0);
        check("rst_out_idx",   64'(out_idx), 64'd0);
        check("rst_out_last",  64'(out_last), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero state.
        for (int i = 0; i < 25; i++) stim[i] = 64'd0;
        send_state(0, 1'b0, 1'b0);
        wait_drain();

        // Single bit in lane 0; pin the model against the hand result.
        fill_single(0, 64'h1);
        send_state(0, 1'b0, 1'b0);
        check("model_single_l0",  exp_lane[0],  64'h1);
        check("model_single_l1",  exp_lane[1],  64'h1);
        check("model_single_l21", exp_lane[21], 64'h1);
        check("model_single_l4",  exp_lane[4],  64'h2);
        check("model_single_l24", exp_lane[24], 64'h2);
        check("model_single_l2",  exp_lane[2],  64'h0);
        wait_drain();

        // Rotation wrap: top bit of lane 2.
        fill_single(2, 64'h8000_0000_0000_0000);
        send_state(20, 1'b0, 1'b0);
        check("model_wrap_l2",  exp_lane[2],  64'h8000_0000_0000_0000);
        check("model_wrap_l16", exp_lane[16], 64'h1);
        check("model_wrap_l23", exp_lane[23], 64'h8000_0000_0000_0000);
        check("model_wrap_l0",  exp_lane[0],  64'h0);
        wait_drain();

        // All ones with random backpressure and junk on in_* during drain.
        for (int i = 0; i < 25; i++) stim[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        rdy_rand = 1'b1;
        send_state(0, 1'b0, 1'b1);
        check("model_ones_l7", exp_lane[7], 64'hFFFF_FFFF_FFFF_FFFF);
        wait_drain();

        // Random states, random input gaps, random backpressure.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 25; i++) stim[i] = {$urandom, $urandom};
            send_state(30, 1'b0, t[0]);
            wait_drain();
        end

        // Reset in the middle of a drain, then a clean single-bit state.
        for (int i = 0; i < 25; i++) stim[i] = {$urandom, $urandom};
        send_state(0, 1'b0, 1'b0);
        guard = 0;
        while (!(out_valid && out_idx == 5'd10) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("reached_idx10", 64'(guard < 2000), 64'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready",  64'(in_ready), 64'd1);
        check("async_rst_out_idx",   64'(out_idx), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_busy",     64'(busy), 64'd0);
        @(posedge clk);
        #1;
        fill_single(0, 64'h1);
        send_state(10, 1'b0, 1'b0);
        wait_drain();

`ifdef KECCAK_THETA_BYPASS_EN
        // Pass-through: lane i carries i+1 and must come out unchanged.
        theta_bypass = 1'b1;
        for (int i = 0; i < 25; i++) stim[i] = 64'(i + 1);
        send_state(0, 1'b1, 1'b0);
        check("model_bypass_l24", exp_lane[24], 64'd25);
        wait_drain();
        theta_bypass = 1'b0;
`endif

        rdy_rand = 1'b0;
        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a handshake never resolves.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_keccak_theta_stream
`default_nettype wire
